mem_access: RTL
===============

# mem_access

Memory-access stage of the five-stage MIPS pipeline, sitting between the EX/MEM register and the MEM/WB register. It executes loads and stores over a req/ack data bus, holding the pipeline with `stallreq` until the bus answers. It aligns, sign- or zero-extends load data and drives the write-back triple `mem_wd`/`mem_wreg`/`mem_wdata` into MEM/WB. Non-memory instructions pass straight through.

## Interface

Parameters: none. The opcodes are fixed 8-bit aluop values:
- LB 0xE0, LH 0xE1, LW 0xE3, LBU 0xE4, LHU 0xE5, SB 0xE8, SH 0xE9, SW 0xEB; any other value is a non-memory op.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-low (`rst`==0 resets on the next rising edge).
- `ex_wd`  in  5  destination register address from EX/MEM.
- `ex_wreg`  in  1  register-write enable from EX/MEM.
- `ex_wdata`  in  32  ALU result (non-memory ops).
- `ex_aluop`  in  8  operation code.
- `ex_mem_addr`  in  32  effective byte address.
- `ex_reg2`  in  32  store data (rt).
- `mem_wd`  out  5  destination address to MEM/WB.
- `mem_wreg`  out  1  write enable to MEM/WB.
- `mem_wdata`  out  32  write-back data to MEM/WB.
- `mem_misalign`  out  1  address-error flag for the current op.
- `stallreq`  out  1  hold EX/MEM and all earlier stages.
- `dbus_req`  out  1  bus request (registered).
- `dbus_we`  out  1  1 = store (registered).
- `dbus_addr`  out  32  word address, {addr[31:2],2'b00} (registered).
- `dbus_sel`  out  4  byte-lane enables, bit 3 = bits 31:24 (registered).
- `dbus_wdata`  out  32  store data (registered).
- `dbus_rdata`  in  32  load data; valid when `dbus_ack`=1.
- `dbus_ack`  in  1  one-cycle completion strobe.

## Operation

- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- Non-memory op in IDLE:
  - `mem_wd`/`mem_wreg`/`mem_wdata` = `ex_wd`/`ex_wreg`/`ex_wdata`, combinationally.
  - `stallreq`=0.
- Misalignment is checked combinationally: LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0.
  - Effect: `mem_misalign`=1, `mem_wreg`=0, no bus access, `stallreq`=0, FSM stays IDLE.
- Aligned memory op in IDLE:
  - `stallreq`=1 and `mem_wreg`=0 (bubble into MEM/WB).
  - Next edge: register the bus fields, set `dbus_req`=1, go to WAIT.
- WAIT:
  - Bus fields are held constant; `stallreq`=1, `mem_wreg`=0.
  - On `dbus_ack`=1: capture `dbus_rdata`, drop `dbus_req` on the same edge, go to DONE.
- DONE:
  - `stallreq`=0; `mem_wd`=`ex_wd`.
  - Loads: `mem_wreg`=`ex_wreg` and `mem_wdata` = extracted captured data.
  - Stores: `mem_wreg`=0 and `mem_wdata`=0.
  - Next edge: unconditionally go to IDLE (EX/MEM advances on that same edge).
- Byte lanes are big-endian:
  - Bytes: addr[1:0]=00 → sel 1000 / bits 31:24, …, 11 → sel 0001 / bits 7:0.
  - Halves: addr[1]=0 → sel 1100 / bits 31:16; addr[1]=1 → sel 0011 / bits 15:0.
  - Words: sel 1111.
- Store data: SB drives {4{reg2[7:0]}}, SH drives {2{reg2[15:0]}}, SW drives reg2.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- `dbus_ack` is ignored in IDLE and DONE.

## Timing

- While `rst`=0, combinational outputs read 0: `mem_wd`, `mem_wreg`, `mem_wdata`, `mem_misalign`, `stallreq`.
- After a reset edge: `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_sel` and `dbus_wdata` are all 0.
- Minimum memory-op occupancy is 3 cycles (IDLE, WAIT with ack, DONE), i.e. 2 stall cycles. Each extra WAIT cycle adds one.
- Result is presented to MEM/WB during DONE and captured at the DONE→IDLE edge.
- Back-to-back memory ops: the second op is seen in IDLE the cycle after DONE, with no lost cycle beyond the FSM sequence.
- Reset asserted in WAIT: the FSM returns to IDLE and `dbus_req` is 0 after that edge. The outstanding request is abandoned, and a late `dbus_ack` is ignored.

## Test plan

- Non-memory op: aluop 0x25, `ex_wd`=3, `ex_wdata`=0x1234 → same cycle `mem_wd`=3, `mem_wreg`=1, `mem_wdata`=0x1234, `stallreq`=0.
- LB with addr 0x101, memory word 0x11F2_3344, ack in the first WAIT cycle:
  - `stallreq` high for 2 cycles; `dbus_sel`=0100, `dbus_addr`=0x100.
  - DONE: `mem_wdata`=0xFFFF_FFF2.
  - LBU on the same data → 0x0000_00F2.
- SH with addr 0x202, reg2 0xABCD_8765: `dbus_we`=1, `dbus_sel`=0011, `dbus_wdata`=0x8765_8765; DONE `mem_wreg`=0.
- LW with ack delayed 4 cycles: bus fields stable throughout WAIT; `stallreq`=1 for 5 cycles; DONE `mem_wdata`=`dbus_rdata`.
- LW at 0x102: `mem_misalign`=1, `dbus_req` stays 0, `stallreq`=0, `mem_wreg`=0.
- `rst`=0 during WAIT: next cycle `dbus_req`=0 and FSM in IDLE. A later `dbus_ack` produces no write-back.

Source files
------------

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- memory-access stage of a five-stage MIPS pipeline.
//
// Runs loads and stores over a req/ack data bus and holds the earlier
// pipeline stages with stallreq until the bus answers. Load data is lane
// aligned (big-endian) and sign/zero extended. Non-memory operations pass
// straight through to MEM/WB.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   ex_wd/ex_wreg/ex_wdata   write-back triple from EX/MEM
//   ex_aluop          operation code (0xE0..0xEB are memory ops)
//   ex_mem_addr       effective byte address
//   ex_reg2           store data
//   mem_wd/mem_wreg/mem_wdata  write-back triple to MEM/WB (combinational)
//   mem_misalign      address-error flag for the current op
//   stallreq          hold EX/MEM and earlier stages
//   dbus_*            registered bus request fields; dbus_rdata/dbus_ack in
// ---------------------------------------------------------------------------
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_wdata,
   input  logic [7:0]  ex_aluop,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_reg2,
   output logic [4:0]  mem_wd,
   output logic        mem_wreg,
   output logic [31:0] mem_wdata,
   output logic        mem_misalign,
   output logic        stallreq,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_sel,
   output logic [31:0] dbus_wdata,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack
);

   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Big-endian byte-lane enables: lane 3 carries bits 31:24.
   function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] a);
      logic [3:0] s;
      s = 4'b0000;
      case (op)
         OP_SB: begin
            case (a)
               2'b00:   s = 4'b1000;
               2'b01:   s = 4'b0100;
               2'b10:   s = 4'b0010;
               default: s = 4'b0001;
            endcase
         end
         OP_SH:   s = a[1] ? 4'b0011 : 4'b1100;
         OP_SW:   s = 4'b1111;
         OP_LB, OP_LBU: begin
            case (a)
               2'b00:   s = 4'b1000;
               2'b01:   s = 4'b0100;
               2'b10:   s = 4'b0010;
               default: s = 4'b0001;
            endcase
         end
         OP_LH, OP_LHU: s = a[1] ? 4'b0011 : 4'b1100;
         OP_LW:   s = 4'b1111;
         default: s = 4'b0000;
      endcase
      return s;
   endfunction

   // Store data is replicated across lanes so the selected lanes carry it.
   function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] r);
      logic [31:0] d;
      d = 32'd0;
      case (op)
         OP_SB:   d = {4{r[7:0]}};
         OP_SH:   d = {2{r[15:0]}};
         OP_SW:   d = r;
         default: d = 32'd0;
      endcase
      return d;
   endfunction

   // Pick the addressed byte/half out of the captured word and extend it.
   function automatic logic [31:0] load_extract(input logic [7:0] op, input logic [1:0] a,
                                                input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (a)
         2'b00:   b = w[31:24];
         2'b01:   b = w[23:16];
         2'b10:   b = w[15:8];
         default: b = w[7:0];
      endcase
      h = a[1] ? w[15:0] : w[31:16];
      case (op)
         OP_LB:   r = {{24{b[7]}}, b};
         OP_LBU:  r = {24'd0, b};
         OP_LH:   r = {{16{h[15]}}, h};
         OP_LHU:  r = {16'd0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   logic [1:0]  state_q, state_d;
   logic        is_load_s, is_store_s, misalign_s, start_s;
   logic        dbus_req_q, dbus_we_q;
   logic [31:0] dbus_addr_q, dbus_wdata_q, rdata_q;
   logic [3:0]  dbus_sel_q;

   // Opcode decode and alignment check.
   always_comb begin
      is_load_s  = 1'b0;
      is_store_s = 1'b0;
      misalign_s = 1'b0;
      case (ex_aluop)
         OP_LB, OP_LBU: is_load_s = 1'b1;
         OP_LH, OP_LHU: begin
            is_load_s  = 1'b1;
            misalign_s = ex_mem_addr[0];
         end
         OP_LW: begin
            is_load_s  = 1'b1;
            misalign_s = |ex_mem_addr[1:0];
         end
         OP_SB: is_store_s = 1'b1;
         OP_SH: begin
            is_store_s = 1'b1;
            misalign_s = ex_mem_addr[0];
         end
         OP_SW: begin
            is_store_s = 1'b1;
            misalign_s = |ex_mem_addr[1:0];
         end
         default: begin
            is_load_s  = 1'b0;
            is_store_s = 1'b0;
            misalign_s = 1'b0;
         end
      endcase
      start_s = (is_load_s | is_store_s) & ~misalign_s;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; ack only matters in WAIT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_s) state_d = ST_WAIT;
            else         state_d = ST_IDLE;
         end
         ST_WAIT: begin
            if (dbus_ack) state_d = ST_DONE;
            else          state_d = ST_WAIT;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus request fields and captured load data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dbus_req_q   <= 1'b0;
         dbus_we_q    <= 1'b0;
         dbus_addr_q  <= 32'd0;
         dbus_sel_q   <= 4'd0;
         dbus_wdata_q <= 32'd0;
         rdata_q      <= 32'd0;
      end else if (state_q == ST_IDLE && start_s) begin
         dbus_req_q   <= 1'b1;
         dbus_we_q    <= is_store_s;
         dbus_addr_q  <= {ex_mem_addr[31:2], 2'b00};
         dbus_sel_q   <= lane_sel(ex_aluop, ex_mem_addr[1:0]);
         dbus_wdata_q <= store_data(ex_aluop, ex_reg2);
      end else if (state_q == ST_WAIT && dbus_ack) begin
         dbus_req_q <= 1'b0;
         rdata_q    <= dbus_rdata;
      end
   end

   // FSM outputs: write-back triple, misalign flag and stall request.
   always_comb begin
      mem_wd       = 5'd0;
      mem_wreg     = 1'b0;
      mem_wdata    = 32'd0;
      mem_misalign = 1'b0;
      stallreq     = 1'b0;
      if (!rst) begin
         mem_wd = 5'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               mem_wd = ex_wd;
               if (misalign_s) begin
                  mem_misalign = 1'b1;
               end else if (start_s) begin
                  stallreq = 1'b1;
               end else begin
                  mem_wreg  = ex_wreg;
                  mem_wdata = ex_wdata;
               end
            end
            ST_WAIT: begin
               mem_wd   = ex_wd;
               stallreq = 1'b1;
            end
            ST_DONE: begin
               mem_wd = ex_wd;
               if (is_load_s) begin
                  mem_wreg  = ex_wreg;
                  mem_wdata = load_extract(ex_aluop, ex_mem_addr[1:0], rdata_q);
               end else begin
                  mem_wreg  = 1'b0;
                  mem_wdata = 32'd0;
               end
            end
            default: begin
               mem_wd = 5'd0;
            end
         endcase
      end
   end

   assign dbus_req   = dbus_req_q;
   assign dbus_we    = dbus_we_q;
   assign dbus_addr  = dbus_addr_q;
   assign dbus_sel   = dbus_sel_q;
   assign dbus_wdata = dbus_wdata_q;

endmodule
